alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_multicycle_mul_iter.sv | 46 ++++
 rtl/alu_multicycle.sv | 119 +++++++++++
 tb/tb_alu_multicycle.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and FSM states shared by alu_multicycle and its tests
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8
    } op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_multicycle_mul_iter.sv
// mul_iter: unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles
module mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end else begin
                r_busy   <= 1'b0;
            end
        end
    end
    // done pulses for one cycle once all WIDTH partial products are summed
    assign done = r_busy && (r_cnt == '0);
    assign prod = r_acc;
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU, single-cycle logic/arith/shift ops plus optional iterative MUL.
// Define ALU_MUL_EN to compile in MUL (op 8); otherwise op 8 is reported as illegal.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);
    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_illegal;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_ovf;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_sra;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic               w_ill;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign illegal   = r_illegal;

`ifdef ALU_MUL_EN
    assign w_is_mul = (op == OP_MUL);
    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_accept && w_is_mul),
        .a     (in1),
        .b     (in2),
        .done  (w_mul_done),
        .prod  (w_prod)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_prod     = '0;
`endif

    // shift amounts at or beyond WIDTH saturate rather than wrap
    assign w_ovf = (in2 >= WIDTH'(WIDTH));
    assign w_amt = in2[SHW-1:0];
    assign w_sra = $signed(in1) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ill = 1'b0;
        case (op)
            OP_ADD: {w_cy, w_res} = {1'b0, in1} + {1'b0, in2};
            OP_SUB: begin
                w_res = in1 - in2;
                w_cy  = (in1 < in2);
            end
            OP_AND: w_res = in1 & in2;
            OP_OR:  w_res = in1 | in2;
            OP_XOR: w_res = in1 ^ in2;
            OP_SLL: w_res = w_ovf ? '0 : in1 << w_amt;
            OP_SRL: w_res = w_ovf ? '0 : in1 >> w_amt;
            OP_SRA: w_res = w_ovf ? {WIDTH{in1[WIDTH-1]}} : w_sra;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state <= w_is_mul ? BUSY : DONE;
                    if (!w_is_mul) begin
                        r_result  <= w_res;
                        r_zero    <= (w_res == '0);
                        r_carry   <= w_cy;
                        r_illegal <= w_ill;
                    end
                end
                BUSY: if (w_mul_done) begin
                    r_state   <= DONE;
                    r_result  <= w_prod[WIDTH-1:0];
                    r_zero    <= (w_prod[WIDTH-1:0] == '0);
                    r_carry   <= |w_prod[2*WIDTH-1:WIDTH];
                    r_illegal <= 1'b0;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
    localparam int W = 8;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, zero, carry, illegal;
    logic [3:0]   op;
    logic [W-1:0] in1, in2, result;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int o, input int a, input int b, output int r, output bit c, output bit ill);
        int p;
        int sa;
        r = 0; c = 0; ill = 0;
        sa = (a >= M / 2) ? a - M : a;
        case (o)
            0: begin p = a + b; r = p % M; c = (p >= M); end
            1: begin r = (a - b + M) % M; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= W) ? 0 : (a << b) % M;
            6: r = (b >= W) ? 0 : a >> b;
            7: r = (b >= W) ? ((sa < 0) ? M - 1 : 0) : (sa >>> b) & (M - 1);
`ifdef ALU_MUL_EN
            8: begin p = a * b; r = p % M; c = (p >= M); end
`endif
            default: ill = 1;
        endcase
    endfunction

    task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int r, lat, exp_lat, t;
        bit c, ill;
        model(o, a, b, r, c, ill);
`ifdef ALU_MUL_EN
        exp_lat = (o == 4'd8) ? W + 1 : 1;
`else
        exp_lat = 1;
`endif
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_before", in_ready, 1);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom); in1 = W'($urandom); in2 = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            check("ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        for (int i = 0; i <= hold; i++) begin
            check("valid", out_valid, 1);
            check("result", result, r);
            check("carry", carry, c);
            check("zero", zero, r == 0);
            check("illegal", illegal, ill);
            check("ready_done", in_ready, 0);
            if (i == hold) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("valid_after", out_valid, 0);
        check("ready_after", in_ready, 1);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        check("rst_illegal", illegal, 0);

        run(4'd0, 8'hF0, 8'h20, 0);
        run(4'd5, 8'h01, 8'd9, 0);
        run(4'd7, 8'h80, 8'd3, 0);
        run(4'd7, 8'h80, 8'd200, 0);
        run(4'd1, 8'h05, 8'h07, 3);
        run(4'hF, 8'h12, 8'h34, 0);
        run(4'd8, 8'd13, 8'd11, 0);
        run(4'd8, 8'd13, 8'd20, 1);

        // reset while the result is waiting in DONE discards it
        op = 4'd0; in1 = 8'd3; in2 = 8'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", in_ready, 1);
        check("abort_result", result, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("abort_no_valid", seen, 0);

`ifdef ALU_MUL_EN
        op = 4'd8; in1 = 8'd13; in2 = 8'd11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mul_abort_ready", in_ready, 1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("mul_abort_no_valid", seen, 0);
`endif
        run(4'd0, 8'd1, 8'd1, 0);

        for (int k = 0; k < 80; k++) begin
            logic [3:0] o;
            logic [W-1:0] b;
            o = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
            run(o, W'($urandom), b, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
